s_bitserial_sub: RTL and testbench

//   Bit-serial signed subtractor: the inverse (difference) counterpart of the flat signed

---
 rtl/s_bitserial_sub.sv | 131 +++++++++++++
 tb/tb_s_bitserial_sub.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/s_bitserial_sub.sv
// Bit-serial signed subtractor: out = a - b as an exact (N+1)-bit two's-complement
// result, one bit per clock through a single full-adder cell and a carry flop.
module s_bitserial_sub #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out,
    output logic         busy
);

    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    // a_sr shifts the minuend out at bit 0 and collects result bits at the top.
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic          carry;
    logic [CW-1:0] cnt;

    logic          accept_c;
    logic          last_c;
    logic          sum_c;
    logic          carry_c;
    logic          ext_c;
    logic          in_ready_d;
    logic          out_valid_d;
    logic          busy_d;

    assign accept_c = in_valid & in_ready;
    assign last_c   = (cnt == CW'(N - 1));
    assign sum_c    = a_sr[0] ^ b_sr[0] ^ carry;
    assign carry_c  = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
    // On the last step bit 0 of each shift register still holds the operand MSBs.
    assign ext_c    = a_sr[0] ^ b_sr[0] ^ carry_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c)  state_next = SHIFT;
            SHIFT:   if (last_c)    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake/status outputs decoded from the next state, then registered
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_next)
            IDLE:    in_ready_d  = 1'b1;
            SHIFT:   busy_d      = 1'b1;
            DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: in_ready_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            busy      <= busy_d;
        end
    end

    // Serial datapath: a + ~b + 1, LSB first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        a_sr  <= a;
                        b_sr  <= ~b;
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    a_sr  <= {sum_c, a_sr[N-1:1]};
                    b_sr  <= {1'b0, b_sr[N-1:1]};
                    carry <= carry_c;
                    cnt   <= cnt + CW'(1);
                    if (last_c) begin
                        out <= {ext_c, sum_c, a_sr[N-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_s_bitserial_sub.sv
// Scoreboard bench for s_bitserial_sub: the driver queues a - b from integer arithmetic,
// a separate monitor checks every presented result, its latency and its stability.
module tb_s_bitserial_sub;

    localparam int unsigned N = 4;
    localparam longint MASK = (longint'(1) << (N + 1)) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   out;
    logic         busy;

    typedef struct {
        longint exp;
        int     acc;
    } item_t;

    item_t  sb[$];
    item_t  e;
    int     cyc = 0;
    int     vectors = 0;
    int     miscompares = 0;
    logic   mon_en = 1'b0;
    logic   rdy_rand = 1'b0;
    logic   man_ready = 1'b0;
    logic   holding = 1'b0;
    logic   nr;
    longint held;

    assign out_ready = mon_en ? rdy_rand : man_ready;

    s_bitserial_sub #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: exact signed difference truncated to N+1 bits.
    function automatic longint model(input int av, input int bv);
        return longint'(av - bv) & MASK;
    endfunction

    task automatic send(input int av, input int bv);
        int w;
        item_t it;
        @(negedge clk);
        a        = N'(av);
        b        = N'(bv);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        it.exp = model(av, bv);
        it.acc = cyc + 1;
        sb.push_back(it);
        @(negedge clk);
        // Scramble operands during SHIFT: result must reflect the accepted values.
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
    endtask

    task automatic wait_valid(input string nm);
        int w;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) chk(nm, 0, 1);
    endtask

    // Monitor: pops on each new result, checks value, latency and hold stability.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                if (!holding) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("result", longint'(out), e.exp);
                        chk("latency", longint'(cyc - e.acc), longint'(N));
                    end
                    held    = longint'(out);
                    holding = 1'b1;
                end else begin
                    chk("hold_stable", longint'(out), held);
                end
                chk("in_ready_in_done", longint'(in_ready), 0);
            end
            nr       = ($urandom_range(0, 3) != 0);
            rdy_rand = nr;
            if (out_valid && nr) holding = 1'b0;
        end else begin
            holding = 1'b0;
        end
    end

    initial begin
        int w;
        int av;
        int bv;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out", longint'(out), 0);
        chk("rst_busy", longint'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release_valid", longint'(out_valid), 0);

        mon_en = 1'b1;
        send(3, 5);
        send(-8, 7);
        send(7, -8);
        send(-8, -8);
        for (int i = -8; i < 8; i++) begin
            for (int j = -8; j < 8; j++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(i, j);
            end
        end
        for (int k = 0; k < 150; k++) begin
            av = $urandom_range(0, 15) - 8;
            bv = $urandom_range(0, 15) - 8;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send(av, bv);
        end
        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk("drain", longint'(sb.size()), 0);

        // Backpressure in DONE with ignored in_valid pulses.
        @(negedge clk);
        mon_en    = 1'b0;
        man_ready = 1'b0;
        send(2, -3);
        sb.delete();
        wait_valid("bp_valid_timeout");
        chk("bp_result", longint'(out), model(2, -3));
        for (int k = 0; k < 10; k++) begin
            in_valid = k[0];
            a        = N'($urandom);
            b        = N'($urandom);
            @(negedge clk);
            chk("bp_out", longint'(out), model(2, -3));
            chk("bp_out_valid", longint'(out_valid), 1);
            chk("bp_in_ready", longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        man_ready = 1'b1;
        @(negedge clk);
        man_ready = 1'b0;
        chk("bp_release_valid", longint'(out_valid), 0);
        chk("bp_release_in_ready", longint'(in_ready), 1);
        chk("bp_release_busy", longint'(busy), 0);
        chk("bp_out_held", longint'(out), model(2, -3));

        // Asynchronous reset in the second SHIFT cycle.
        send(5, -3);
        sb.delete();
        @(posedge clk);
        #1;
        chk("mid_busy", longint'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", longint'(in_ready), 1);
        chk("mid_rst_out_valid", longint'(out_valid), 0);
        chk("mid_rst_busy", longint'(busy), 0);
        chk("mid_rst_out", longint'(out), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        send(1, 1);
        send(5, -3);
        w = 0;
        while ((sb.size() != 0 || out_valid) && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("final_drain", longint'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
